// File: rtl/fifo_pkg.sv
// Shared FIFO constants and helpers, reused by the sync and async FIFO families.
package fifo_pkg;

   localparam int DEFAULT_DATA_WIDTH   = 14;
   localparam int DEFAULT_ADDR_WIDTH   = 4;
   localparam int DEFAULT_AFULL_LEVEL  = 14;
   localparam int DEFAULT_AEMPTY_LEVEL = 2;

   // Smallest n such that 2**n >= value; clog2(1) = 0.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous (combinational) read.
module fifo_ram
   import fifo_pkg::*;
#(
   parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter  int DEPTH      = 1 << DEFAULT_ADDR_WIDTH,
   localparam int AW         = clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // NOTE: the array has no reset; clearing it would turn the RAM into a flop bank
   // and gains nothing, since control logic never exposes an unwritten entry.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock first-word-fall-through FIFO using all 2**ADDR_WIDTH entries,
// with occupancy count, programmable almost-full/empty flags and error pulses.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
   parameter int AFULL_LEVEL  = DEFAULT_AFULL_LEVEL,
   parameter int AEMPTY_LEVEL = DEFAULT_AEMPTY_LEVEL
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  fifo_full,
   output logic                  fifo_empty,
   output logic                  fifo_afull,
   output logic                  fifo_aempty,
   output logic [ADDR_WIDTH:0]   fifo_count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_CNT  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AFULL_CNT  = (ADDR_WIDTH+1)'(AFULL_LEVEL);
   localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);

   generate
      if (!(AEMPTY_LEVEL >= 0 && AEMPTY_LEVEL < AFULL_LEVEL && AFULL_LEVEL <= DEPTH)) begin : g_bad_levels
         $error("sync_fifo_param: need 0 <= AEMPTY_LEVEL < AFULL_LEVEL <= DEPTH");
      end
   endgenerate

   logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0] count_q, count_d;
   logic                overflow_q, overflow_d;
   logic                underflow_q, underflow_d;
   logic                wr_acc, rd_acc;

   assign fifo_full   = (count_q == DEPTH_CNT);
   assign fifo_empty  = (count_q == '0);
   assign fifo_afull  = (count_q >= AFULL_CNT);
   assign fifo_aempty = (count_q <= AEMPTY_CNT);
   assign fifo_count  = count_q;
   assign overflow    = overflow_q;
   assign underflow   = underflow_q;

   // A write into a full FIFO is legal when the head leaves in the same cycle.
   always_comb begin
      // NOTE: every signal gets a default first so no path through this block can infer a latch.
      rd_acc      = rd_en & ~fifo_empty;
      wr_acc      = wr_en & (~fifo_full | rd_acc);
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = wr_en & ~wr_acc;
      underflow_d = rd_en & ~rd_acc;

      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;

      if (wr_acc && !rd_acc) begin
         count_d = count_q + 1'b1;
      end else if (rd_acc && !wr_acc) begin
         count_d = count_q - 1'b1;
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (wr_acc & ~rst),
      .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
      .wdata (wr_data),
      .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param at default parameters (14-bit data, 16 entries).
module tb_sync_fifo_param;

   localparam int DW = 14;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          rd_en;
   logic [DW-1:0] rd_data;
   logic          fifo_full, fifo_empty, fifo_afull, fifo_aempty;
   logic [AW:0]   fifo_count;
   logic          overflow, underflow;

   int tests_run = 0;
   int tests_failed = 0;

   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] head;

   sync_fifo_param dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .fifo_full   (fifo_full),
      .fifo_empty  (fifo_empty),
      .fifo_afull  (fifo_afull),
      .fifo_aempty (fifo_aempty),
      .fifo_count  (fifo_count),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      assert (observed === expected)
      else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
   task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic re);
      wr_en   = we;
      wr_data = wd;
      rd_en   = re;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic check_flags(input string tag, input int cnt, input logic ovf, input logic unf);
      check({tag, " count"},  32'(fifo_count),  32'(cnt));
      check({tag, " empty"},  32'(fifo_empty),  32'(cnt == 0));
      check({tag, " full"},   32'(fifo_full),   32'(cnt == 16));
      check({tag, " afull"},  32'(fifo_afull),  32'(cnt >= 14));
      check({tag, " aempty"}, 32'(fifo_aempty), 32'(cnt <= 2));
      check({tag, " overflow"},  32'(overflow),  32'(ovf));
      check({tag, " underflow"}, 32'(underflow), 32'(unf));
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cycle(1'b0, '0, 1'b0);
      check_flags("reset idle", 0, 1'b0, 1'b0);

      // Fill with 0x0001..0x0010; head stays at the first word throughout.
      for (int i = 1; i <= 16; i++) begin
         cycle(1'b1, DW'(i), 1'b0);
         check_flags($sformatf("fill %0d", i), i, 1'b0, 1'b0);
         check($sformatf("fill %0d head", i), 32'(rd_data), 32'h1);
      end

      cycle(1'b1, 14'h3FFF, 1'b0);
      check_flags("overflow pulse", 16, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b0);
      check_flags("overflow clear", 16, 1'b0, 1'b0);

      // Drain in order.
      for (int i = 1; i <= 16; i++) begin
         check($sformatf("drain %0d data", i), 32'(rd_data), 32'(i));
         cycle(1'b0, '0, 1'b1);
         check($sformatf("drain %0d count", i), 32'(fifo_count), 32'(16 - i));
      end
      check_flags("drained", 0, 1'b0, 1'b0);

      cycle(1'b0, '0, 1'b1);
      check_flags("underflow pulse", 0, 1'b0, 1'b1);
      cycle(1'b0, '0, 1'b0);
      check_flags("underflow clear", 0, 1'b0, 1'b0);

      // A rejected read must not have moved rd_ptr: the next write becomes the head.
      cycle(1'b1, 14'h0055, 1'b0);
      check("ptr after underflow data", 32'(rd_data), 32'h55);
      check_flags("ptr after underflow", 1, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1);
      check_flags("re-empty", 0, 1'b0, 1'b0);

      // Full with simultaneous push/pop across the pointer wrap.
      exp_q.delete();
      for (int i = 0; i < 16; i++) begin
         cycle(1'b1, DW'(100 + i), 1'b0);
         exp_q.push_back(DW'(100 + i));
      end
      check_flags("refill", 16, 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) begin
         head = exp_q.pop_front();
         check($sformatf("stream %0d data", k), 32'(rd_data), 32'(head));
         cycle(1'b1, DW'(200 + k), 1'b1);
         exp_q.push_back(DW'(200 + k));
         check_flags($sformatf("stream %0d", k), 16, 1'b0, 1'b0);
      end
      for (int i = 0; i < 16; i++) begin
         head = exp_q.pop_front();
         check($sformatf("post-stream %0d data", i), 32'(rd_data), 32'(head));
         cycle(1'b0, '0, 1'b1);
      end
      check_flags("post-stream empty", 0, 1'b0, 1'b0);

      // Empty with simultaneous push/pop: write lands, read is rejected.
      cycle(1'b1, 14'h02A5, 1'b1);
      check_flags("empty push-pop", 1, 1'b0, 1'b1);
      check("empty push-pop data", 32'(rd_data), 32'h2A5);
      cycle(1'b0, '0, 1'b1);
      check_flags("empty push-pop drain", 0, 1'b0, 1'b0);

      // Reset with 5 entries held, write request present in the reset cycle.
      for (int i = 0; i < 5; i++) cycle(1'b1, DW'(i + 7), 1'b0);
      check_flags("pre-reset", 5, 1'b0, 1'b0);
      rst = 1'b1;
      cycle(1'b1, 14'h1234, 1'b1);
      rst = 1'b0;
      check_flags("mid reset", 0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0);
      check_flags("after reset", 0, 1'b0, 1'b0);
      cycle(1'b1, 14'h0ABC, 1'b0);
      check("after reset head", 32'(rd_data), 32'hABC);
      check_flags("after reset write", 1, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised FIFO; next generation of the team's 16x14 stream buffer.
- Generalised data width and depth; uses all 2^ADDR_WIDTH entries (extra pointer wrap bit); programmable almost-full/almost-empty thresholds; occupancy count; overflow/underflow pulses.
- Sits between AXI4-Stream master logic and its data source, inside one clock domain.
- First-word-fall-through read port.

Parameters:
- DATA_WIDTH, 14, width of wr_data/rd_data.
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2^ADDR_WIDTH (default 16).
- AFULL_LEVEL, 14, fifo_afull asserted when count >= AFULL_LEVEL.
- AEMPTY_LEVEL, 2, fifo_aempty asserted when count <= AEMPTY_LEVEL.
- Legal only if 0 <= AEMPTY_LEVEL < AFULL_LEVEL <= DEPTH; elaboration-time check fails otherwise.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read request (pops the current head).
- rd_data  out  DATA_WIDTH  head of FIFO (FWFT), valid while fifo_empty=0.
- fifo_full  out  1  count == DEPTH.
- fifo_empty  out  1  count == 0.
- fifo_afull  out  1  count >= AFULL_LEVEL.
- fifo_aempty  out  1  count <= AEMPTY_LEVEL.
- fifo_count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- State: wr_ptr and rd_ptr, each ADDR_WIDTH+1 bits; registered count; overflow/underflow regs. The memory array is not reset.
- On rst=1 at an edge: wr_ptr=rd_ptr=0, count=0, overflow=underflow=0.
  - Resulting outputs: fifo_empty=1, fifo_full=0, fifo_afull=0 (AFULL_LEVEL>0), fifo_aempty=1, fifo_count=0.
  - rst overrides wr_en/rd_en in the same cycle. Reset mid-operation discards all contents.
- Accept rules, evaluated on pre-edge state:
  - wr_acc = wr_en & (~fifo_full | rd_acc)
  - rd_acc = rd_en & ~fifo_empty
- Write on wr_acc: mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data; wr_ptr += 1, wrapping modulo 2^(ADDR_WIDTH+1).
- Read on rd_acc: rd_ptr += 1, same wrap.
- Count update: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
- Full with simultaneous wr_en & rd_en: both accepted, count stays DEPTH, no overflow.
- Empty with simultaneous wr_en & rd_en: write accepted, read rejected, underflow pulses, count becomes 1.
- overflow <= wr_en & ~wr_acc; underflow <= rd_en & ~rd_acc.
  - Both are registered, asserted for exactly the cycle after the offending request.
- rd_data = mem[rd_ptr[ADDR_WIDTH-1:0]], combinational (async-read RAM).
  - After a write to an empty FIFO at edge N, fifo_empty=0 and rd_data is valid immediately after edge N (one-cycle write-to-read latency).
  - While empty, rd_data is don't-care.
- Flags are combinational decodes of registered count; no other combinational paths from inputs to outputs.
- Sanity relation: fifo_full implies wr_ptr and rd_ptr differ only in the MSB; fifo_empty implies the pointers are equal.

Decomposition:
- Package/header fifo_pkg:
  - clog2 function;
  - default DATA_WIDTH=14, ADDR_WIDTH=4;
  - threshold defaults.
  - The same constants are reused by async_fifo successors.
- Sub-module fifo_ram:
  - simple dual-port, DEPTH x DATA_WIDTH;
  - synchronous write, asynchronous read;
  - ports clk, we, waddr, wdata, raddr, rdata.
- Control (pointers, count, flags, error pulses) stays in sync_fifo_param.

Test Plan:
- Reset then idle → fifo_empty=1, fifo_aempty=1, fifo_count=0, fifo_full=0, no error pulses. Assert rst with FIFO holding 5 entries → next cycle count=0, empty=1.
- Write 16 words 0x0001..0x0010 back-to-back → count steps 1..16; fifo_aempty drops when count=3; fifo_afull rises when count=14; fifo_full rises when count=16. A 17th wr_en → overflow pulse one cycle, count stays 16.
- From full, read 16 words → rd_data sequence 0x0001..0x0010 in order; fifo_empty at count=0. Extra rd_en → underflow pulse, rd_ptr unchanged.
- Full FIFO, wr_en=rd_en=1 for 20 cycles with incrementing data → count stays 16, no overflow, output order preserved across pointer wrap.
- Empty FIFO, wr_en=rd_en=1 with data 0x2A5 → underflow pulses, count=1, next cycle rd_data=0x2A5.
- Re-elaborate with DATA_WIDTH=32, ADDR_WIDTH=6, AFULL_LEVEL=60, AEMPTY_LEVEL=4; random 50/50 wr/rd for 10k cycles against a scoreboard model → data and flags match every cycle. Illegal AEMPTY_LEVEL=AFULL_LEVEL fails elaboration.
